answer_poller: RTL and testbench

Bus-side initiator for the answer register window. After a start pulse it sweeps `addr` from 0 to N_WORDS-1, waits the responder's registered read latency, and captures every returned `data` byte into a local frame buffer. It then streams the captured frame out through a valid/ready byte interface toward the UART transmitter. The frame is a header byte, N_WORDS payload bytes and an 8-bit checksum. The block sits between the answer register window and the UART TX path of the simulator link.

---
 rtl/answer_pkg.sv | 16 +
 rtl/frame_tx_mux.sv | 64 ++++++
 rtl/answer_poller.sv | 127 ++++++++++++
 tb/tb_answer_poller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/answer_pkg.sv
// Shared widths, defaults and FSM state codes for the answer register poller.
package answer_pkg;

  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned N_WORDS_DEF = 18;
  localparam logic [BYTE_W-1:0] HDR_DEF = 8'hA5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_POLL = 2'd1;
  localparam state_t ST_SEND = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

endpackage

// File: rtl/frame_tx_mux.sv
// Frame byte selector (header, payload, checksum) with the valid/ready output register.
module frame_tx_mux
  import answer_pkg::*;
#(
  parameter int unsigned       N_WORDS = N_WORDS_DEF,
  parameter logic [BYTE_W-1:0] HDR     = HDR_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_load,
  input  logic [N_WORDS-1:0][BYTE_W-1:0]  i_frame,
  input  logic [BYTE_W-1:0]               i_chk,
  input  logic                            i_tx_ready,
  output logic [BYTE_W-1:0]               o_tx_data,
  output logic                            o_tx_valid,
  output logic                            o_last_c
);

  localparam int unsigned IDX_W = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS + 1);

  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [BYTE_W-1:0] w_byte;
  logic              w_xfer;

  assign w_xfer = r_valid & i_tx_ready;

  // Byte 0 is the header, 1..N_WORDS the payload, the final index the checksum.
  always_comb begin
    w_sel_idx = i_load ? '0 : r_idx + IDX_W'(1);
    w_byte    = HDR;
    if (w_sel_idx == LAST_IDX) w_byte = i_chk;
    for (int unsigned i = 0; i < N_WORDS; i++) begin
      if (w_sel_idx == IDX_W'(i + 1)) w_byte = i_frame[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_idx   <= '0;
      r_data  <= w_byte;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      if (r_idx == LAST_IDX) begin
        r_valid <= 1'b0;
      end else begin
        r_idx  <= w_sel_idx;
        r_data <= w_byte;
      end
    end
  end

  assign o_tx_data  = r_data;
  assign o_tx_valid = r_valid;
  assign o_last_c   = w_xfer & (r_idx == LAST_IDX);

endmodule

// File: rtl/answer_poller.sv
// Polls the answer register window into a frame buffer and streams it out as
// header, payload and checksum over a valid/ready byte interface.
module answer_poller
  import answer_pkg::*;
#(
  parameter int unsigned       N_WORDS = N_WORDS_DEF,
  parameter int unsigned       RD_LAT  = 1,
  parameter logic [BYTE_W-1:0] HDR     = HDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] frame_cnt
);

  localparam int unsigned WAIT   = RD_LAT + 1;
  localparam int unsigned WCNT_W = $clog2(WAIT) + 1;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [ADDR_W-1:0]               r_addr;
  logic [WCNT_W-1:0]               r_wait;
  logic [BYTE_W-1:0]               r_chk;
  logic [N_WORDS-1:0][BYTE_W-1:0]  r_frame;
  logic                            r_busy;
  logic                            r_done;
  logic [BYTE_W-1:0]               r_frame_cnt;
  logic                            w_cap;
  logic                            w_last_word;
  logic                            w_send_load;
  logic                            w_last_xfer;

  // Capture on the final edge of each address hold window.
  assign w_cap       = (r_state == ST_POLL) && (r_wait == WCNT_W'(WAIT - 1));
  assign w_last_word = (r_addr == ADDR_W'(N_WORDS - 1));
  assign w_send_load = w_cap & w_last_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)       w_state_nxt = ST_POLL;
      ST_POLL: if (w_send_load) w_state_nxt = ST_SEND;
      ST_SEND: if (w_last_xfer) w_state_nxt = ST_FIN;
      ST_FIN:                   w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_wait      <= '0;
      r_chk       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_addr <= '0;
            r_wait <= '0;
            r_chk  <= '0;
          end
        end
        ST_POLL: begin
          if (w_cap) begin
            r_chk  <= r_chk + data;
            r_wait <= '0;
            if (!w_last_word) r_addr <= r_addr + ADDR_W'(1);
          end else begin
            r_wait <= r_wait + WCNT_W'(1);
          end
        end
        ST_FIN: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_addr      <= '0;
          r_frame_cnt <= r_frame_cnt + BYTE_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset branch here.
  for (genvar g = 0; g < N_WORDS; g++) begin : g_frame
    always_ff @(posedge clk) begin
      if (w_cap && (r_addr == ADDR_W'(g))) r_frame[g] <= data;
    end
  end

  frame_tx_mux #(
    .N_WORDS (N_WORDS),
    .HDR     (HDR)
  ) u_tx_mux (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_send_load),
    .i_frame    (r_frame),
    .i_chk      (r_chk),
    .i_tx_ready (tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_last_c   (w_last_xfer)
  );

  assign addr      = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_answer_poller.sv
// Bench for answer_poller: responder models, frame reference model, vector table
// and hand-written corner sequences.
module tb_answer_poller;

  localparam int unsigned NW = 18;
  localparam int unsigned NB = NW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, ready_a, ready_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic [7:0] txd_a, txd_b, fc_a, fc_b;
  logic       txv_a, txv_b, busy_a, busy_b, done_a, done_b;

  answer_poller #(.N_WORDS(NW), .RD_LAT(1), .HDR(8'hA5)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .addr(addr_a), .data(data_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(ready_a),
    .busy(busy_a), .done(done_a), .frame_cnt(fc_a));

  answer_poller #(.N_WORDS(NW), .RD_LAT(3), .HDR(8'hA5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .addr(addr_b), .data(data_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(ready_b),
    .busy(busy_b), .done(done_b), .frame_cnt(fc_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Responder register map: counter at 0, 10k at 1..15, 0x52 at 16, 0 at 17.
  function automatic logic [7:0] resp_val(input logic [4:0] a, input logic [7:0] c);
    if (a == 5'd0)  return c;
    if (a <= 5'd15) return 8'(10 * a);
    if (a == 5'd16) return 8'h52;
    return 8'h00;
  endfunction

  logic [7:0] cnt_a = 8'h00, cnt_b = 8'h00;
  logic [4:0] prev_a = 5'd0, prev_b = 5'd0;
  logic [7:0] p0_b = 8'h00, p1_b = 8'h00;

  always @(posedge clk) begin
    data_a <= resp_val(addr_a, cnt_a);
    if (addr_a == 5'd17 && prev_a != 5'd17) cnt_a <= cnt_a + 8'd1;
    prev_a <= addr_a;
  end

  always @(posedge clk) begin
    p0_b   <= resp_val(addr_b, cnt_b);
    p1_b   <= p0_b;
    data_b <= p1_b;
    if (addr_b == 5'd17 && prev_b != 5'd17) cnt_b <= cnt_b + 8'd1;
    prev_b <= addr_b;
  end

  // Transfer monitors, sampled on the falling edge.
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int         done_cnt_a = 0, done_cnt_b = 0;
  logic       stall_a = 1'b0;
  logic [7:0] stall_d_a = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("hold_valid", 32'(txv_a), 32'd1);
        check("hold_data", 32'(txd_a), 32'(stall_d_a));
      end
      if (txv_a && ready_a) got_a.push_back(txd_a);
      if (done_a) done_cnt_a++;
      stall_a   = txv_a && !ready_a;
      stall_d_a = txd_a;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (txv_b && ready_b) got_b.push_back(txd_b);
      if (done_b) done_cnt_b++;
    end
  end

  logic [7:0] exp_q[$];
  bit         rnd_ready = 1'b0;

  task automatic mk_exp(input logic [7:0] c);
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < int'(NW); k++) begin
      exp_q.push_back(resp_val(5'(k), c));
      sum += int'(resp_val(5'(k), c));
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) ready_a = 1'($urandom_range(0, 1));
  endtask

  task automatic cmp_frame(input string nm, input bit use_b);
    logic [7:0] g[$];
    if (use_b) g = got_b;
    else       g = got_a;
    check({nm, "_len"}, 32'(g.size()), 32'(exp_q.size()));
    for (int i = 0; i < g.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", nm, i), 32'(g[i]), 32'(exp_q[i]));
  endtask

  task automatic run_frame_a(input bit rnd, output int lat, output int fv);
    int n;
    mk_exp(cnt_a);
    got_a.delete();
    done_cnt_a = 0;
    ready_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    rnd_ready = rnd;
    lat = -1;
    fv  = -1;
    n   = 0;
    while (n < 2000) begin
      step();
      n++;
      if (fv < 0 && txv_a) fv = n;
      if (done_a) begin
        lat = n;
        break;
      end
    end
    rnd_ready = 1'b0;
    ready_a = 1'b1;
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    step();
    check("done_pulses", 32'(done_cnt_a), 32'd1);
    check("busy_after", 32'(busy_a), 32'd0);
    cmp_frame("frame_a", 1'b0);
  endtask

  typedef struct {
    bit         rnd;
    logic [7:0] b1;
    logic [7:0] chk;
    logic [7:0] fc;
    int         lat;
    int         fv;
  } vec_t;

  vec_t vt[4];
  int   lat, fv, bad;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    vt[0] = '{1'b0, 8'h00, 8'h02, 8'd1, 57, 36};
    vt[1] = '{1'b0, 8'h01, 8'h03, 8'd2, 57, 36};
    vt[2] = '{1'b1, 8'h02, 8'h04, 8'd3, 0, 0};
    vt[3] = '{1'b1, 8'h03, 8'h05, 8'd4, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr_a", 32'(addr_a), 32'd0);
    check("rst_txd_a", 32'(txd_a), 32'd0);
    check("rst_txv_a", 32'(txv_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_fc_a", 32'(fc_a), 32'd0);
    check("rst_txv_b", 32'(txv_b), 32'd0);
    check("rst_fc_b", 32'(fc_b), 32'd0);
    rst = 1'b1;
    step();
    step();

    for (int i = 0; i < 4; i++) begin
      run_frame_a(vt[i].rnd, lat, fv);
      check("frame_cnt", 32'(fc_a), 32'(vt[i].fc));
      if (got_a.size() == NB) begin
        check("byte1", 32'(got_a[1]), 32'(vt[i].b1));
        check("chk", 32'(got_a[NB-1]), 32'(vt[i].chk));
      end
      if (vt[i].lat != 0) begin
        check("latency", 32'(lat), 32'(vt[i].lat));
        check("first_valid", 32'(fv), 32'(vt[i].fv));
      end
      check("resp_cnt", 32'(cnt_a), 32'(i + 1));
    end

    // Start pulses during POLL and SEND must be ignored and not queued.
    mk_exp(cnt_a);
    got_a.delete();
    done_cnt_a = 0;
    start_a = 1'b1;
    step();
    for (int n = 1; n <= 120; n++) begin
      start_a = (n == 10 || n == 45);
      step();
    end
    start_a = 1'b0;
    check("ign_done_pulses", 32'(done_cnt_a), 32'd1);
    check("ign_frame_cnt", 32'(fc_a), 32'd5);
    check("ign_busy", 32'(busy_a), 32'd0);
    cmp_frame("ign", 1'b0);

    // Reset while byte 7 of SEND is presented.
    got_a.delete();
    done_cnt_a = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 0; n < 200 && got_a.size() < 7; n++) step();
    check("pre_rst_valid", 32'(txv_a), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_txv", 32'(txv_a), 32'd0);
    check("mid_rst_txd", 32'(txd_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_addr", 32'(addr_a), 32'd0);
    check("mid_rst_fc", 32'(fc_a), 32'd0);
    step();
    step();
    rst = 1'b1;
    repeat (5) step();
    check("abort_no_done", 32'(done_cnt_a), 32'd0);
    check("abort_bytes", 32'(got_a.size()), 32'd7);

    run_frame_a(1'b0, lat, fv);
    check("post_rst_fc", 32'(fc_a), 32'd1);
    check("post_rst_latency", 32'(lat), 32'd57);

    // Three-cycle read latency: each address held four clocks.
    mk_exp(cnt_b);
    got_b.delete();
    done_cnt_b = 0;
    bad = 0;
    lat = -1;
    fv  = -1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (n < 72 && addr_b !== 5'(n / 4)) bad++;
      if (fv < 0 && txv_b) fv = n;
      if (done_b) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("b_done_timeout", 32'd0, 32'd1);
    step();
    check("b_addr_hold", 32'(bad), 32'd0);
    check("b_first_valid", 32'(fv), 32'd72);
    check("b_latency", 32'(lat), 32'd93);
    check("b_done_pulses", 32'(done_cnt_b), 32'd1);
    check("b_frame_cnt", 32'(fc_b), 32'd1);
    cmp_frame("frame_b", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
